aes128_rd_sched: RTL and testbench
==================================

Name: aes128_rd_sched

Overview:
Read-side sequencer for the AES-128 accelerator. On start it fetches the 128-bit key line, then streams N source cache lines from host memory. It issues tagged read requests under channel-0 almost-full and an outstanding-request cap, and forwards responses, which may return out of order, to the cipher datapath with their line index. It sits between the HardCloud control/buffer registers and the CCI-P c0 request/response path.

Parameters:
MAX_OUTSTANDING, 64, maximum read requests in flight (power of 2, 2..256)
ADDR_W, 42, cache-line address width (byte address >> 6)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; begin a job (HC_CONTROL_START)
stop  in  1  one-cycle pulse; abort job (HC_CONTROL_STOP)
key_addr  in  ADDR_W  cache-line address of key buffer; sampled at start
src_addr  in  ADDR_W  cache-line address of source buffer; sampled at start
num_lines  in  32  source lines to read; sampled at start
tx_almfull  in  1  c0 TX almost-full; no request may issue while high
ds_almfull  in  1  downstream block FIFO almost-full; no data request may issue while high
rd_req_valid  out  1  read request valid (registered)
rd_req_addr  out  ADDR_W  request line address
rd_req_tag  out  16  mdata tag: bit15=1 key, else line index[14:0]
rd_rsp_valid  in  1  read response valid
rd_rsp_tag  in  16  response mdata
rd_rsp_data  in  512  response line
key_valid  out  1  one-cycle pulse; key holds rd_rsp_data[127:0]
key  out  128  latched key
blk_valid  out  1  one-cycle pulse per data line
blk_idx  out  32  line index of blk_data
blk_data  out  512  data line
busy  out  1  state != S_RD_IDLE
done  out  1  one-cycle pulse on leaving S_RD_FINISH
aborted  out  1  sticky; set by stop, cleared by next start

Behaviour:
- Reset (reset_n=0 at an edge): state S_RD_IDLE; every output 0; outstanding, issue and receive counters 0. A reset mid-job discards everything. Responses arriving after reset are ignored.
- Counters: issued_cnt, rcvd_cnt (32b); outstanding (log2(MAX_OUTSTANDING)+1 b). outstanding +1 on issue, -1 on an accepted response. Issue and response in the same cycle leave it unchanged.
- Issue is registered: when the issue condition holds at an edge, rd_req_* are driven for exactly the next cycle. Otherwise rd_req_valid=0.
- S_RD_IDLE: on start, latch key_addr/src_addr/num_lines, clear counters and aborted, go to S_RD_FETCH_KEY. stop is ignored in this state.
- S_RD_FETCH_KEY: issue one request (addr=key_addr, tag=16'h8000) when !tx_almfull. Then hold until a response with tag[15]=1 arrives. Latch key, pulse key_valid the next cycle, go to S_RD_FETCH.
- S_RD_FETCH: issue line issued_cnt when !tx_almfull && !ds_almfull && outstanding<MAX_OUTSTANDING.
  - addr = src_addr + issued_cnt (mod 2^ADDR_W wrap); tag = {1'b0, issued_cnt[14:0]}.
  - Go to S_RD_WAIT at the edge that issues the final line (issued_cnt becomes num_lines).
  - If num_lines==0, go directly to S_RD_WAIT.
- S_RD_WAIT: no issue. When outstanding==0 go to S_RD_FINISH.
- S_RD_FINISH: one cycle. done pulses the cycle after, then S_RD_IDLE.
- Data response (tag[15]=0) in FETCH/WAIT: next cycle blk_valid=1, blk_data=rd_rsp_data, blk_idx = reconstructed index. Reconstruction uses the lowest index ≥ rcvd-window base whose low 15 bits equal the tag. Because MAX_OUTSTANDING ≤ 2^14, this is unambiguous. rcvd_cnt increments.
- Responses are never backpressured. ds_almfull only gates issue, so the downstream FIFO must absorb MAX_OUTSTANDING lines after asserting almfull.
- stop in FETCH_KEY/FETCH/WAIT: set aborted; suppress new issues; go to S_RD_WAIT and drain. Draining responses are counted but blk_valid/key_valid stay 0. Then FINISH/done as normal.
- start while busy: ignored. start and stop in the same cycle in IDLE: start wins.
- Response with tag[15]=1 outside FETCH_KEY: dropped, but outstanding still decrements if nonzero.

Test Plan:
- Basic: key_addr=0x100, src_addr=0x200, num_lines=4, no almfull -> requests tag 8000@0x100, then 0@0x200..3@0x203. Key returned -> key_valid with key=data[127:0]. 4 blk_valid, done exactly once, busy falls the same cycle done rises.
- Out-of-order: num_lines=8, responses returned in reverse order -> blk_idx sequence 7..0 with matching data, done after the 8th.
- Throttle: MAX_OUTSTANDING=4, num_lines=10, responses withheld -> exactly 4 requests then stall. Release one response -> exactly one new request. tx_almfull=1 for 5 cycles -> zero requests in that window.
- num_lines=0 -> key fetch only. done 2 cycles after key_valid; no data requests.
- Abort: num_lines=100, stop after 10 issued with 6 returned -> no further requests, 4 drained responses with no blk_valid, aborted=1, done pulses. Next start clears aborted.
- Reset mid-job: reset_n=0 for 1 cycle during FETCH -> all outputs 0, state IDLE. A late response produces no blk_valid. A new start runs cleanly.

Source files
------------

// File: rtl/aes128_rd_sched.sv
// aes128_rd_sched: fetches the AES-128 key line, then streams N source lines over CCI-P c0,
// throttled by almost-full and an outstanding cap; out-of-order responses are re-indexed.
module aes128_rd_sched #(
  parameter int MAX_OUTSTANDING = 64,
  parameter int ADDR_W = 42
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] key_addr,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [31:0]       num_lines,
  input  logic              tx_almfull,
  input  logic              ds_almfull,
  output logic              rd_req_valid,
  output logic [ADDR_W-1:0] rd_req_addr,
  output logic [15:0]       rd_req_tag,
  input  logic              rd_rsp_valid,
  input  logic [15:0]       rd_rsp_tag,
  input  logic [511:0]      rd_rsp_data,
  output logic              key_valid,
  output logic [127:0]      key,
  output logic              blk_valid,
  output logic [31:0]       blk_idx,
  output logic [511:0]      blk_data,
  output logic              busy,
  output logic              done,
  output logic              aborted
);
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  typedef enum logic [2:0] {S_RD_IDLE, S_RD_FETCH_KEY, S_RD_FETCH, S_RD_WAIT, S_RD_FINISH} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] key_q, src_q;
  logic [31:0] num_q, issued_cnt, rcvd_cnt, idx_cand;
  logic [OW-1:0] outstanding;
  logic key_sent, issue_key, issue_dat, issue, key_got, rsp_acc, dat_acc;
  assign busy = state != S_RD_IDLE;
  always_comb begin
    issue_key = state == S_RD_FETCH_KEY && !stop && !key_sent && !tx_almfull;
    issue_dat = state == S_RD_FETCH && !stop && !tx_almfull && !ds_almfull &&
                outstanding < OW'(MAX_OUTSTANDING) && issued_cnt < num_q;
    issue = issue_key || issue_dat;
    key_got = state == S_RD_FETCH_KEY && !stop && rd_rsp_valid && rd_rsp_tag[15];
    rsp_acc = rd_rsp_valid && state != S_RD_IDLE && outstanding != '0;
    dat_acc = rd_rsp_valid && !rd_rsp_tag[15] && (state == S_RD_FETCH || state == S_RD_WAIT);
    // in-flight lines all sit within 2^15 below the issue pointer, so the tag picks one
    idx_cand = {issued_cnt[31:15], rd_rsp_tag[14:0]};
    state_nxt = state;
    case (state)
      S_RD_IDLE:      state_nxt = start ? S_RD_FETCH_KEY : S_RD_IDLE;
      S_RD_FETCH_KEY: state_nxt = stop ? S_RD_WAIT : !key_got ? S_RD_FETCH_KEY :
                                  num_q == '0 ? S_RD_WAIT : S_RD_FETCH;
      S_RD_FETCH:     state_nxt = (stop || num_q == '0 || (issue_dat && issued_cnt + 32'd1 == num_q)) ?
                                  S_RD_WAIT : S_RD_FETCH;
      S_RD_WAIT:      state_nxt = outstanding == '0 ? S_RD_FINISH : S_RD_WAIT;
      S_RD_FINISH:    state_nxt = S_RD_IDLE;
      default:        state_nxt = S_RD_IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= !reset_n ? S_RD_IDLE : state_nxt;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_req_valid <= 1'b0;
      rd_req_addr <= '0;
      rd_req_tag <= '0;
      key_valid <= 1'b0;
      key <= '0;
      blk_valid <= 1'b0;
      blk_idx <= '0;
      blk_data <= '0;
      done <= 1'b0;
      aborted <= 1'b0;
      key_q <= '0;
      src_q <= '0;
      num_q <= '0;
      issued_cnt <= '0;
      rcvd_cnt <= '0;
      outstanding <= '0;
      key_sent <= 1'b0;
    end else begin
      rd_req_valid <= issue;
      rd_req_addr <= issue_key ? key_q : src_q + ADDR_W'(issued_cnt);
      rd_req_tag <= issue_key ? 16'h8000 : {1'b0, issued_cnt[14:0]};
      outstanding <= outstanding + OW'(issue) - OW'(rsp_acc);
      issued_cnt <= issued_cnt + 32'(issue_dat);
      rcvd_cnt <= rcvd_cnt + 32'(dat_acc);
      key_sent <= key_sent || issue_key;
      key_valid <= key_got;
      key <= key_got ? rd_rsp_data[127:0] : key;
      blk_valid <= dat_acc && !aborted;
      blk_data <= dat_acc ? rd_rsp_data : blk_data;
      blk_idx <= !dat_acc ? blk_idx : idx_cand >= issued_cnt ? idx_cand - 32'h8000 : idx_cand;
      done <= state == S_RD_FINISH;
      if (stop && (state == S_RD_FETCH_KEY || state == S_RD_FETCH || state == S_RD_WAIT))
        aborted <= 1'b1;
      if (state == S_RD_IDLE && start) begin
        key_q <= key_addr;
        src_q <= src_addr;
        num_q <= num_lines;
        issued_cnt <= '0;
        rcvd_cnt <= '0;
        outstanding <= '0;
        key_sent <= 1'b0;
        aborted <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_aes128_rd_sched.sv
// tb_aes128_rd_sched: directed scoreboard bench; instance a uses the default cap, b a cap of 4.
module tb_aes128_rd_sched;
  typedef logic [543:0] v_t;
  logic clk = 0, reset_n = 0, start_a = 0, start_b = 0, stop = 0, tx_almfull = 0, ds_almfull = 0;
  logic rsp_v = 0, sel = 0;
  logic [41:0] key_addr = '0, src_addr = '0;
  logic [31:0] num_lines = '0;
  logic [15:0] rsp_tag = '0;
  logic [511:0] rsp_data = '0;
  logic a_req_valid, a_key_valid, a_blk_valid, a_busy, a_done, a_aborted;
  logic b_req_valid, b_key_valid, b_blk_valid, b_busy, b_done, b_aborted;
  logic [41:0] a_req_addr, b_req_addr;
  logic [15:0] a_req_tag, b_req_tag;
  logic [127:0] a_key, b_key;
  logic [31:0] a_blk_idx, b_blk_idx;
  logic [511:0] a_blk_data, b_blk_data;
  logic m_req_valid, m_key_valid, m_blk_valid, m_busy, m_done, m_aborted;
  logic [41:0] m_req_addr;
  logic [15:0] m_req_tag;
  logic [127:0] m_key;
  logic [31:0] m_blk_idx;
  logic [511:0] m_blk_data;
  int checks = 0, failures = 0, n_req = 0, n_blk = 0, n_key = 0, n_done = 0, cyc = 0, kv_cyc = 0, dn_cyc = 0;
  logic prev_busy = 0;
  logic [127:0] exp_key;
  logic [57:0] exp_req[$];
  logic [543:0] exp_blk[$];

  always #5 clk = ~clk;

  aes128_rd_sched dut_a (.clk(clk), .reset_n(reset_n), .start(start_a), .stop(stop), .key_addr(key_addr),
    .src_addr(src_addr), .num_lines(num_lines), .tx_almfull(tx_almfull), .ds_almfull(ds_almfull),
    .rd_req_valid(a_req_valid), .rd_req_addr(a_req_addr), .rd_req_tag(a_req_tag), .rd_rsp_valid(rsp_v),
    .rd_rsp_tag(rsp_tag), .rd_rsp_data(rsp_data), .key_valid(a_key_valid), .key(a_key),
    .blk_valid(a_blk_valid), .blk_idx(a_blk_idx), .blk_data(a_blk_data), .busy(a_busy), .done(a_done),
    .aborted(a_aborted));
  aes128_rd_sched #(.MAX_OUTSTANDING(4)) dut_b (.clk(clk), .reset_n(reset_n), .start(start_b), .stop(stop),
    .key_addr(key_addr), .src_addr(src_addr), .num_lines(num_lines), .tx_almfull(tx_almfull),
    .ds_almfull(ds_almfull), .rd_req_valid(b_req_valid), .rd_req_addr(b_req_addr), .rd_req_tag(b_req_tag),
    .rd_rsp_valid(rsp_v), .rd_rsp_tag(rsp_tag), .rd_rsp_data(rsp_data), .key_valid(b_key_valid),
    .key(b_key), .blk_valid(b_blk_valid), .blk_idx(b_blk_idx), .blk_data(b_blk_data), .busy(b_busy),
    .done(b_done), .aborted(b_aborted));

  always_comb begin
    m_req_valid = sel ? b_req_valid : a_req_valid;
    m_req_addr  = sel ? b_req_addr : a_req_addr;
    m_req_tag   = sel ? b_req_tag : a_req_tag;
    m_key_valid = sel ? b_key_valid : a_key_valid;
    m_key       = sel ? b_key : a_key;
    m_blk_valid = sel ? b_blk_valid : a_blk_valid;
    m_blk_idx   = sel ? b_blk_idx : a_blk_idx;
    m_blk_data  = sel ? b_blk_data : a_blk_data;
    m_busy      = sel ? b_busy : a_busy;
    m_done      = sel ? b_done : a_done;
    m_aborted   = sel ? b_aborted : a_aborted;
  end

  task automatic chk(input string tag, input v_t obs, input v_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] dfun(input int i);
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = 32'(i) * 32'h9E3779B1 + 32'(k);
    return d;
  endfunction

  always @(posedge clk) begin
    #1;
    cyc++;
    if (m_req_valid) begin
      n_req++;
      if (exp_req.size() == 0) chk("req_unexpected", v_t'({m_req_addr, m_req_tag}), '0);
      else chk("req", v_t'({m_req_addr, m_req_tag}), v_t'(exp_req.pop_front()));
    end
    if (m_blk_valid) begin
      n_blk++;
      if (exp_blk.size() == 0) chk("blk_unexpected", v_t'({m_blk_idx, m_blk_data}), '0);
      else chk("blk", v_t'({m_blk_idx, m_blk_data}), exp_blk.pop_front());
    end
    if (m_key_valid) begin
      n_key++;
      kv_cyc = cyc;
      chk("key", v_t'(m_key), v_t'(exp_key));
    end
    if (m_done) begin
      n_done++;
      dn_cyc = cyc;
      chk("busy_at_done", v_t'(m_busy), v_t'(0));
      chk("busy_before_done", v_t'(prev_busy), v_t'(1));
    end
    prev_busy = m_busy;
  end

  task automatic push_req(input logic [41:0] a, input logic [15:0] t);
    exp_req.push_back({a, t});
  endtask

  task automatic push_job(input logic [41:0] k, input logic [41:0] s, input int n);
    push_req(k, 16'h8000);
    for (int i = 0; i < n; i++) push_req(s + 42'(i), {1'b0, 15'(i)});
  endtask

  task automatic go(input logic s, input logic [41:0] k, input logic [41:0] sa, input logic [31:0] n);
    sel = s;
    key_addr = k;
    src_addr = sa;
    num_lines = n;
    if (s) start_b = 1;
    else start_a = 1;
    @(negedge clk);
    start_a = 0;
    start_b = 0;
  endtask

  task automatic rsp(input logic [15:0] t, input logic [511:0] d);
    rsp_v = 1;
    rsp_tag = t;
    rsp_data = d;
    @(negedge clk);
    rsp_v = 0;
  endtask

  task automatic rsp_key(input int j);
    logic [511:0] d;
    d = dfun(j + 1000);
    exp_key = d[127:0];
    rsp(16'h8000, d);
  endtask

  task automatic rsp_line(input int i, input logic expect_blk);
    if (expect_blk) exp_blk.push_back({32'(i), dfun(i)});
    rsp({1'b0, 15'(i)}, dfun(i));
  endtask

  task automatic wait_req(input int tgt);
    int t = 0;
    while (n_req < tgt && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("wait_req", v_t'(n_req >= tgt), v_t'(1));
  endtask

  task automatic wait_done(input int tgt);
    int t = 0;
    while (n_done < tgt && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("wait_done", v_t'(n_done), v_t'(tgt));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_flags"}, v_t'({a_busy, a_done, a_aborted, a_req_valid, a_key_valid, a_blk_valid,
                              b_busy, b_done, b_aborted, b_req_valid, b_key_valid, b_blk_valid}), '0);
    chk({tag, "_data"}, v_t'({a_key, a_blk_idx, a_req_addr, a_req_tag}), '0);
    chk({tag, "_blk"}, v_t'(a_blk_data), '0);
  endtask

  initial begin
    int b, d, nb;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    reset_n = 1;
    @(negedge clk);
    // basic
    b = n_req; d = n_done;
    push_job(42'h100, 42'h200, 4);
    go(0, 42'h100, 42'h200, 4);
    chk("basic_busy", v_t'(m_busy), v_t'(1));
    wait_req(b + 1);
    rsp_key(1);
    wait_req(b + 5);
    for (int i = 0; i < 4; i++) rsp_line(i, 1);
    wait_done(d + 1);
    repeat (3) @(negedge clk);
    chk("basic_done_once", v_t'(n_done), v_t'(d + 1));
    chk("basic_key_cnt", v_t'(n_key), v_t'(1));
    // out-of-order
    b = n_req; d = n_done; nb = n_blk;
    push_job(42'h50, 42'h1000, 8);
    go(0, 42'h50, 42'h1000, 8);
    wait_req(b + 1);
    rsp_key(2);
    wait_req(b + 9);
    for (int i = 7; i >= 0; i--) rsp_line(i, 1);
    wait_done(d + 1);
    chk("ooo_blk_cnt", v_t'(n_blk - nb), v_t'(8));
    // throttle on the cap-4 instance
    b = n_req; d = n_done;
    push_job(42'h10, 42'h2000, 10);
    go(1, 42'h10, 42'h2000, 10);
    wait_req(b + 1);
    rsp_key(3);
    repeat (10) @(negedge clk);
    chk("thr_cap", v_t'(n_req - b), v_t'(5));
    rsp_line(0, 1);
    repeat (6) @(negedge clk);
    chk("thr_release", v_t'(n_req - b), v_t'(6));
    tx_almfull = 1;
    rsp_line(1, 1);
    repeat (4) @(negedge clk);
    chk("thr_almfull", v_t'(n_req - b), v_t'(6));
    tx_almfull = 0;
    repeat (3) @(negedge clk);
    chk("thr_resume", v_t'(n_req - b), v_t'(7));
    for (int i = 2; i < 10; i++) begin
      wait_req(b + 2 + i);
      rsp_line(i, 1);
    end
    wait_done(d + 1);
    // zero lines
    b = n_req; d = n_done;
    push_job(42'h40, 42'h0, 0);
    go(0, 42'h40, 42'h0, 0);
    wait_req(b + 1);
    rsp_key(4);
    wait_done(d + 1);
    chk("zero_done_gap", v_t'(dn_cyc - kv_cyc), v_t'(2));
    // abort
    b = n_req; d = n_done;
    push_job(42'h7, 42'h3000, 10);
    go(0, 42'h7, 42'h3000, 100);
    wait_req(b + 1);
    rsp_key(5);
    wait_req(b + 11);
    ds_almfull = 1;
    nb = n_blk;
    for (int i = 0; i < 6; i++) rsp_line(i, 1);
    stop = 1;
    @(negedge clk);
    stop = 0;
    for (int i = 6; i < 10; i++) rsp_line(i, 0);
    wait_done(d + 1);
    chk("abort_flag", v_t'(m_aborted), v_t'(1));
    chk("abort_blk_cnt", v_t'(n_blk - nb), v_t'(6));
    ds_almfull = 0;
    b = n_req; d = n_done;
    push_job(42'h8, 42'h4000, 2);
    go(0, 42'h8, 42'h4000, 2);
    chk("abort_cleared", v_t'(m_aborted), v_t'(0));
    wait_req(b + 1);
    rsp_key(6);
    wait_req(b + 3);
    rsp_line(1, 1);
    rsp_line(0, 1);
    wait_done(d + 1);
    // reset mid-job
    b = n_req; d = n_done;
    push_job(42'h9, 42'h5000, 6);
    go(0, 42'h9, 42'h5000, 6);
    wait_req(b + 1);
    rsp_key(7);
    wait_req(b + 4);
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    chk_idle("midreset");
    exp_req.delete();
    nb = n_blk;
    rsp_line(0, 0);
    repeat (3) @(negedge clk);
    chk("late_rsp_ignored", v_t'(n_blk - nb), v_t'(0));
    b = n_req; d = n_done;
    push_job(42'h11, 42'h6000, 2);
    go(0, 42'h11, 42'h6000, 2);
    wait_req(b + 1);
    rsp_key(8);
    wait_req(b + 3);
    rsp_line(0, 1);
    rsp_line(1, 1);
    wait_done(d + 1);
    repeat (4) @(negedge clk);
    chk("req_queue_empty", v_t'(exp_req.size()), v_t'(0));
    chk("blk_queue_empty", v_t'(exp_blk.size()), v_t'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
